immediate_formatter: RTL and testbench
======================================

IMMEDIATE_FORMATTER -- requirements
Module: immediate_formatter

Interface
REQ-001: Parameter UPPERCASE, default 1, meaning hex letters A-F are emitted as uppercase when 1 and lowercase when 0.
REQ-002: Parameter SUPPRESS_ZEROS, default 1, meaning leading zero nibbles are skipped when 1 and all 8 digits are emitted when 0.
REQ-003: Parameter TERMINATOR, default 8'h27 ("'"), meaning the character emitted after the last digit.
REQ-004: Port clk_in, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005: Port rst_n_in, input, 1 bit: reset, synchronous and active-low.
REQ-006: Port trigger_in, input, 1 bit: start request; sampled only in IDLE.
REQ-007: Port immediate_in, input, 32 bits: value to format; captured on an accepted trigger.
REQ-008: Port ready_in, input, 1 bit: downstream accepts ascii_out this cycle.
REQ-009: Port ascii_out, output, 8 bits: current character.
REQ-010: Port ascii_valid, output, 1 bit: ascii_out holds a valid character.
REQ-011: Port busy_flag, output, 1 bit: high in every state except IDLE.
REQ-012: Port done_flag, output, 1 bit: one-cycle pulse after the terminator is accepted.

Function
REQ-013: States are IDLE, EMIT, TERM and DONE.
REQ-014: In IDLE with trigger_in=1, the block SHALL register immediate_in into an internal shift register.
REQ-015: On the same trigger, the block SHALL compute and register the digit count: 8 when SUPPRESS_ZEROS=0; otherwise 8 minus the number of leading zero nibbles, with a minimum of 1.
REQ-016: On the same trigger, the block SHALL left-align the shift register so its top nibble is the first digit to emit, then enter EMIT.
REQ-017: Latency: a trigger in cycle N SHALL give ascii_valid=1 with the first digit in cycle N+1.
REQ-018: In EMIT, ascii_out SHALL be the ASCII code of the top nibble: "0"-"9" for values 0-9, and "A"-"F" or "a"-"f" per UPPERCASE for values 10-15.
REQ-019: A character is transferred in a cycle where ascii_valid=1 and ready_in=1.
REQ-020: While ascii_valid=1 and ready_in=0, ascii_out SHALL hold stable.
REQ-021: On each transfer in EMIT, the block SHALL shift the register left by 4 and decrement the remaining-digit counter.
REQ-022: On transfer of the last digit (counter = 1), the block SHALL enter TERM.
REQ-023: In TERM, ascii_out SHALL equal TERMINATOR with ascii_valid=1; on transfer the block SHALL enter DONE.
REQ-024: In DONE, ascii_valid=0 and done_flag=1 for exactly one cycle, then the block SHALL return to IDLE.
REQ-025: ascii_valid SHALL be 0 in IDLE and DONE.
REQ-026: In IDLE, ascii_out SHALL be 8'h00.
REQ-027: trigger_in SHALL be ignored in EMIT, TERM and DONE; immediate_in changes after capture SHALL have no effect.
REQ-028: Back-to-back operation: a trigger in the cycle after DONE (block back in IDLE) SHALL be accepted.
REQ-029: Zero value: immediate_in=0 SHALL emit exactly "0" then TERMINATOR when SUPPRESS_ZEROS=1, and "00000000" then TERMINATOR when SUPPRESS_ZEROS=0.
REQ-030: Every operation SHALL emit exactly (digit count + 1) characters.

Reset
REQ-031: When rst_n_in=0 at a rising edge, the block SHALL enter IDLE in any state, including mid-emission, and abandon the current value without emitting a terminator.
REQ-032: Reset values: ascii_valid=0, ascii_out=8'h00, busy_flag=0, done_flag=0, shift register=0, counter=0.
REQ-033: Reset SHALL take priority over trigger_in.

Verification
REQ-034: Defaults; trigger with 32'hDEADBEEF; ready_in held 1 -> "D","E","A","D","B","E","E","F","'" on 9 consecutive cycles starting N+1; done_flag pulse at N+10.
REQ-035: Defaults; trigger with 32'h000000A5 -> "A","5","'"; then trigger with 32'h00000000 -> "0","'"; busy_flag low only between the two operations.
REQ-036: UPPERCASE=0, SUPPRESS_ZEROS=0; trigger with 32'h0000BEEF -> "0","0","0","0","b","e","e","f","'".
REQ-037: 32'h12345678 with ready_in low for 3 cycles during "3" -> "3" held stable with ascii_valid=1; sequence resumes "4".."8","'" with no loss or duplication; trigger_in pulsed mid-stream is ignored.
REQ-038: Reset (rst_n_in=0) asserted while emitting the 3rd digit of 32'hCAFEF00D -> next cycle ascii_valid=0, busy_flag=0, no terminator; a following trigger with 32'h1 -> "1","'".

Source files
------------

// File: rtl/immediate_formatter.sv
// Formats a captured 32-bit value as hex ASCII characters on a valid/ready stream,
// optionally dropping leading zeros, followed by a terminator character.
module immediate_formatter #(
  parameter bit         UPPERCASE      = 1'b1,
  parameter bit         SUPPRESS_ZEROS = 1'b1,
  parameter logic [7:0] TERMINATOR     = 8'h27
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        trigger_in,
  input  logic [31:0] immediate_in,
  input  logic        ready_in,
  output logic [7:0]  ascii_out,
  output logic        ascii_valid,
  output logic        busy_flag,
  output logic        done_flag
);

  typedef enum logic [1:0] {IDLE, EMIT, TERM, DONE} state_t;

  state_t      state_q;
  logic [31:0] shift_q;
  logic [3:0]  cnt_q;
  logic [7:0]  ascii_q;
  logic        valid_q;
  logic        busy_q;
  logic        done_q;

  logic [3:0]  digits_d;
  logic [3:0]  lead_d;
  logic [31:0] aligned_d;
  logic [31:0] shift_d;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    logic [7:0] base;
    base = UPPERCASE ? 8'h41 : 8'h61;
    if (nib < 4'd10) hex_char = 8'h30 + {4'h0, nib};
    else             hex_char = base + {4'h0, nib} - 8'd10;
  endfunction

  // Highest non-zero nibble sets the width; a zero value still yields one digit.
  function automatic logic [3:0] digit_count(input logic [31:0] v);
    digit_count = 4'd1;
    if (!SUPPRESS_ZEROS) begin
      digit_count = 4'd8;
    end else begin
      for (int i = 1; i < 8; i++) begin
        if (v[4*i +: 4] != 4'h0) digit_count = 4'(i + 1);
      end
    end
  endfunction

  always_comb begin
    digits_d  = digit_count(immediate_in);
    lead_d    = 4'd8 - digits_d;
    aligned_d = immediate_in << {lead_d, 2'b00};
    shift_d   = {shift_q[27:0], 4'h0};
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      shift_q <= 32'h0;
      cnt_q   <= 4'd0;
      ascii_q <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ascii_q <= 8'h00;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          if (trigger_in) begin
            shift_q <= aligned_d;
            cnt_q   <= digits_d;
            ascii_q <= hex_char(aligned_d[31:28]);
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= EMIT;
          end
        end
        EMIT: begin
          if (ready_in) begin
            shift_q <= shift_d;
            cnt_q   <= cnt_q - 4'd1;
            // Output is registered, so present the character that follows this transfer.
            if (cnt_q == 4'd1) begin
              ascii_q <= TERMINATOR;
              state_q <= TERM;
            end else begin
              ascii_q <= hex_char(shift_q[27:24]);
            end
          end
        end
        TERM: begin
          if (ready_in) begin
            ascii_q <= 8'h00;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ascii_out   = ascii_q;
  assign ascii_valid = valid_q;
  assign busy_flag   = busy_q;
  assign done_flag   = done_q;

endmodule

// File: tb/tb_immediate_formatter.sv
// Bench for immediate_formatter: default instance (a) and lowercase/no-suppression instance (b)
// checked against a string-level model of the expected character stream.
module tb_immediate_formatter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ready;
  logic        trig_a, trig_b;
  logic [31:0] imm;
  logic [7:0]  a_ascii, b_ascii;
  logic        a_valid, a_busy, a_done;
  logic        b_valid, b_busy, b_done;

  int checks = 0;
  int errors = 0;

  byte unsigned qa[$];
  byte unsigned qb[$];
  bit           pv[2];
  bit           pr[2];
  logic [7:0]   pa[2];
  bit           exp_done[2];

  always #5 clk = ~clk;

  immediate_formatter dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .trigger_in(trig_a), .immediate_in(imm),
    .ready_in(ready), .ascii_out(a_ascii), .ascii_valid(a_valid),
    .busy_flag(a_busy), .done_flag(a_done)
  );

  immediate_formatter #(.UPPERCASE(1'b0), .SUPPRESS_ZEROS(1'b0), .TERMINATOR(8'h27)) dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .trigger_in(trig_b), .immediate_in(imm),
    .ready_in(ready), .ascii_out(b_ascii), .ascii_valid(b_valid),
    .busy_flag(b_busy), .done_flag(b_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%s required=%s", name, act, exp);
    end
  endtask

  // Expected text: hex digits, optional case fold, optional leading-zero strip, then terminator.
  function automatic string model_str(input logic [31:0] v, input bit up, input bit sup);
    string        s;
    byte unsigned c;
    s = $sformatf("%08h", v);
    for (int i = 0; i < s.len(); i++) begin
      c = s.getc(i);
      if (up && c >= "a" && c <= "f") s.putc(i, c - 8'd32);
    end
    while (sup && s.len() > 1 && s.getc(0) == "0") s = s.substr(1, s.len() - 1);
    return {s, "'"};
  endfunction

  task automatic push_exp(input int id, input logic [31:0] v);
    string s;
    s = model_str(v, id == 0, id == 0);
    for (int i = 0; i < s.len(); i++) begin
      if (id == 0) qa.push_back(s.getc(i));
      else         qb.push_back(s.getc(i));
    end
  endtask

  task automatic compare_one(input int id, input logic [7:0] a, input logic v,
                             input logic busy, input logic done);
    byte unsigned e;
    int           qsize;
    if (!rst_n) begin
      if (id == 0) qa.delete(); else qb.delete();
      exp_done[id] = 1'b0;
      pv[id] = 1'b0;
      pr[id] = 1'b1;
      return;
    end
    qsize = (id == 0) ? qa.size() : qb.size();
    if (exp_done[id]) begin
      chk($sformatf("dut%0d_done_pulse", id), {30'h0, done, v}, 32'h2);
      exp_done[id] = 1'b0;
    end else begin
      chk($sformatf("dut%0d_no_done", id), {31'h0, done}, 32'h0);
    end
    chk($sformatf("dut%0d_busy", id), {31'h0, busy}, {31'h0, v | done});
    if (!v && !done) chk($sformatf("dut%0d_idle_ascii", id), {24'h0, a}, 32'h0);
    if (pv[id] && !pr[id]) begin
      chk($sformatf("dut%0d_hold_valid", id), {31'h0, v}, 32'h1);
      chk($sformatf("dut%0d_hold_ascii", id), {24'h0, a}, {24'h0, pa[id]});
    end
    if (v && qsize == 0) begin
      checks++;
      errors++;
      $display("FAIL dut%0d_unexpected_char actual=%0h required=none", id, a);
    end else if (v && ready) begin
      if (id == 0) e = qa.pop_front(); else e = qb.pop_front();
      chk($sformatf("dut%0d_char", id), {24'h0, a}, {24'h0, e});
      if (qsize == 1) exp_done[id] = 1'b1;
    end
    pv[id] = v;
    pr[id] = ready;
    pa[id] = a;
  endtask

  task automatic sample();
    @(negedge clk);
    compare_one(0, a_ascii, a_valid, a_busy, a_done);
    compare_one(1, b_ascii, b_valid, b_busy, b_done);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample();
    adv();
  endtask

  task automatic run_until_done(input int id, input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      sample();
      seen = (id == 0) ? a_done : b_done;
      adv();
    end
    chk($sformatf("dut%0d_done_within_bound", id), {31'h0, seen}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    ready  = 1'b1;
    trig_a = 1'b0;
    trig_b = 1'b0;
    imm    = 32'h0;
    adv();
    repeat (2) tick();
    rst_n = 1'b1;
    sample();
    chk("reset_a_valid", {31'h0, a_valid}, 32'h0);
    chk("reset_a_ascii", {24'h0, a_ascii}, 32'h0);
    chk("reset_a_busy",  {31'h0, a_busy},  32'h0);
    chk("reset_a_done",  {31'h0, a_done},  32'h0);
    chk("reset_b_valid", {31'h0, b_valid}, 32'h0);
    adv();

    chk_str("model_deadbeef", model_str(32'hDEADBEEF, 1, 1), "DEADBEEF'");
    chk_str("model_a5",       model_str(32'h000000A5, 1, 1), "A5'");
    chk_str("model_zero",     model_str(32'h00000000, 1, 1), "0'");
    chk_str("model_beef_raw", model_str(32'h0000BEEF, 0, 0), "0000beef'");

    // DEADBEEF with ready held: digits N+1..N+8, terminator N+9, done N+10
    imm = 32'hDEADBEEF; trig_a = 1'b1; push_exp(0, imm);
    tick();
    trig_a = 1'b0; imm = 32'h0;
    for (int k = 1; k <= 10; k++) begin
      sample();
      if (k == 1) begin
        chk("deadbeef_first_valid", {31'h0, a_valid}, 32'h1);
        chk("deadbeef_first_char", {24'h0, a_ascii}, 32'h44);
      end
      if (k == 9) chk("deadbeef_term", {24'h0, a_ascii}, 32'h27);
      if (k == 10) chk("deadbeef_done_n10", {31'h0, a_done}, 32'h1);
      adv();
    end

    // A5 then zero back to back
    imm = 32'h000000A5; trig_a = 1'b1; push_exp(0, imm);
    tick();
    trig_a = 1'b0;
    run_until_done(0, 20);
    imm = 32'h0; trig_a = 1'b1; push_exp(0, imm);
    sample();
    chk("b2b_idle_busy_low", {31'h0, a_busy}, 32'h0);
    adv();
    trig_a = 1'b0;
    sample();
    chk("zero_busy", {31'h0, a_busy}, 32'h1);
    chk("zero_char", {24'h0, a_ascii}, 32'h30);
    adv();
    run_until_done(0, 20);

    // Lowercase, no suppression
    imm = 32'h0000BEEF; trig_b = 1'b1; push_exp(1, imm);
    tick();
    trig_b = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      sample();
      if (k == 1) chk("beef_first_zero", {24'h0, b_ascii}, 32'h30);
      if (k == 5) chk("beef_lower_b", {24'h0, b_ascii}, 32'h62);
      adv();
    end
    run_until_done(1, 20);
    imm = 32'h0; trig_b = 1'b1; push_exp(1, imm);
    tick();
    trig_b = 1'b0;
    run_until_done(1, 20);

    // Backpressure during "3" with an ignored mid-stream trigger
    imm = 32'h12345678; trig_a = 1'b1; push_exp(0, imm);
    tick();
    trig_a = 1'b0;
    tick();
    tick();
    ready = 1'b0;
    sample();
    chk("stall_char3_a", {24'h0, a_ascii}, 32'h33);
    adv();
    trig_a = 1'b1; imm = 32'hFFFFFFFF;
    sample();
    chk("stall_char3_b", {25'h0, a_valid, a_ascii[7:2]}, {25'h0, 1'b1, 6'h0C});
    adv();
    trig_a = 1'b0;
    sample();
    chk("stall_char3_c", {24'h0, a_ascii}, 32'h33);
    adv();
    ready = 1'b1;
    run_until_done(0, 20);

    // Reset while the third digit of CAFEF00D is presented
    imm = 32'hCAFEF00D; trig_a = 1'b1; push_exp(0, imm);
    tick();
    trig_a = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    sample();
    chk("cafe_third_char", {24'h0, a_ascii}, 32'h46);
    adv();
    rst_n = 1'b1;
    sample();
    chk("rst_mid_valid", {31'h0, a_valid}, 32'h0);
    chk("rst_mid_busy",  {31'h0, a_busy},  32'h0);
    chk("rst_mid_ascii", {24'h0, a_ascii}, 32'h0);
    adv();
    tick();
    imm = 32'h1; trig_a = 1'b1; push_exp(0, imm);
    tick();
    trig_a = 1'b0;
    sample();
    chk("after_rst_char", {24'h0, a_ascii}, 32'h31);
    adv();
    run_until_done(0, 20);

    repeat (3) tick();
    chk("queue_a_drained", qa.size(), 32'h0);
    chk("queue_b_drained", qb.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
